// File: rtl/uart_rx_controller_pkg.sv
// Shared constants, state encoding and small helpers for the UART frame receiver.
package uart_rx_controller_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int SYNC_STAGES    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Bit centre within one bit period, counted in oversampling ticks.
    function automatic int centre_tick(input int oversample);
        return oversample / 2;
    endfunction

    // Minimum counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Bundle of the receiver's tick/enable/line inputs and its frame result outputs.
interface uart_rx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_ENABLE;
    logic                 Rx_EN;
    logic                 RxD;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_PERROR;
    logic                 Rx_FERROR;
    logic                 Rx_BUSY;

    modport master (
        output sample_ENABLE,
        output Rx_EN,
        output RxD,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR,
        input  Rx_BUSY
    );

    modport slave (
        input  sample_ENABLE,
        input  Rx_EN,
        input  RxD,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR,
        output Rx_BUSY
    );
endinterface

// File: rtl/uart_rx_controller_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_controller_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/uart_rx_controller.sv
// UART 8N-E-1 frame sequencer: start detect, centre sampling, even parity and stop checks.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_rx_controller_if.slave   rx
);
    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [TW-1:0] MID_TICK  = TW'(centre_tick(OVERSAMPLE));
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state_reg;
    logic [TW-1:0]        tick_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 perror_reg;
    logic                 ferror_reg;
    logic                 busy_reg;
    logic                 centre;
    logic                 bit_end;

    uart_rx_controller_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx.RxD),
        .q     (rxd_s)
    );

    assign centre  = (tick_cnt_reg == MID_TICK);
    assign bit_end = (tick_cnt_reg == LAST_TICK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_err_reg  <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perror_reg   <= 1'b0;
            ferror_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            // Disabling the receiver abandons a frame even if a tick arrives in the same cycle.
            if (state_reg != ST_IDLE && !rx.Rx_EN) begin
                state_reg    <= ST_IDLE;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                busy_reg     <= 1'b0;
            end else if (rx.sample_ENABLE) begin
                if (state_reg != ST_IDLE) begin
                    tick_cnt_reg <= tick_cnt_reg + 1'b1;
                end
                case (state_reg)
                    ST_IDLE: begin
                        // The detection tick counts as tick 0 of the start bit.
                        if (rx.Rx_EN && !rxd_s) begin
                            state_reg    <= ST_START;
                            tick_cnt_reg <= TW'(1);
                            bit_cnt_reg  <= '0;
                            busy_reg     <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (centre && rxd_s) begin
                            state_reg    <= ST_IDLE;
                            tick_cnt_reg <= '0;
                            busy_reg     <= 1'b0;
                        end else if (bit_end) begin
                            state_reg <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (centre) begin
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                        end else if (bit_end) begin
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_PARITY;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (centre) begin
                            par_err_reg <= rxd_s ^ (^shift_reg);
                        end else if (bit_end) begin
                            state_reg <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Finish at the stop-bit centre so a new start bit can follow immediately.
                        if (centre) begin
                            data_reg     <= shift_reg;
                            perror_reg   <= par_err_reg;
                            ferror_reg   <= ~rxd_s;
                            valid_reg    <= 1'b1;
                            state_reg    <= ST_IDLE;
                            tick_cnt_reg <= '0;
                            busy_reg     <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        tick_cnt_reg <= '0;
                        busy_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.Rx_DATA   = data_reg;
    assign rx.Rx_VALID  = valid_reg;
    assign rx.Rx_PERROR = perror_reg;
    assign rx.Rx_FERROR = ferror_reg;
    assign rx.Rx_BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed and randomized frame bench for uart_rx_controller with a frame-level reference model.
module tb_uart_rx_controller;

    localparam int BIT_CLKS  = 16;
    localparam int HIST_SIZE = 2048;
    // Start edge to strobe: 2 sync flops + detection edge + stop centre at tick 168.
    localparam int VALID_EDGE = 2 + 1 + (10 * 16 + 8);

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   div = 0;
    int   div_cnt = 0;
    logic div_tick = 1'b0;

    logic       line_q[$];
    logic [7:0] vdata_q[$];
    logic       vperr_q[$];
    logic       vferr_q[$];
    int         vedge_q[$];
    logic       busy_hist [0:HIST_SIZE-1];
    int         abort_edge = 0;
    logic [7:0] last_data = 8'h00;

    always #5 clk = ~clk;

    uart_rx_controller_if #(.DATA_BITS(8)) bus ();

    uart_rx_controller #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    // Stand-in for the baud generator: one-cycle pulse every div clocks, or constant high.
    always @(posedge clk) begin
        if (div == 0) begin
            div_cnt  <= 0;
            div_tick <= 1'b0;
        end else if (div_cnt >= div - 1) begin
            div_cnt  <= 0;
            div_tick <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1;
            div_tick <= 1'b0;
        end
    end

    assign bus.sample_ENABLE = (div == 0) ? 1'b1 : div_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int cpb);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < cpb; c++) line_q.push_back(bits[b]);
        end
    endtask

    // Plays the queued line waveform one value per clock; edge e is the e-th posedge after the first drive.
    task automatic play(input int ncycles);
        vdata_q.delete();
        vperr_q.delete();
        vferr_q.delete();
        vedge_q.delete();
        @(negedge clk);
        bus.RxD = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
        for (int e = 1; e <= ncycles; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < HIST_SIZE) busy_hist[e] = bus.Rx_BUSY;
            if (bus.Rx_VALID === 1'b1) begin
                vdata_q.push_back(bus.Rx_DATA);
                vperr_q.push_back(bus.Rx_PERROR);
                vferr_q.push_back(bus.Rx_FERROR);
                vedge_q.push_back(e);
            end
            bus.RxD = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
            if (abort_edge != 0 && e == abort_edge - 1) bus.Rx_EN = 1'b0;
        end
        line_q.delete();
        bus.RxD = 1'b1;
    endtask

    // Reference: the frame yields its data byte, a parity error when the total of ones is odd,
    // and a framing error when the stop bit is 0, all strobed VALID_EDGE clocks after the start edge.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pbit, input logic sbit);
        logic exp_perr;
        logic exp_ferr;
        exp_perr = pbit ^ (^d);
        exp_ferr = ~sbit;
        push_frame(d, pbit, sbit, BIT_CLKS);
        play(11 * BIT_CLKS + 40);
        $display("frame %s: data=%02h parity=%0b stop=%0b strobes=%0d", tag, d, pbit, sbit, vdata_q.size());
        check({tag, " strobes"}, vdata_q.size(), 1);
        if (vdata_q.size() > 0) begin
            check({tag, " data"}, vdata_q[0], d);
            check({tag, " perr"}, vperr_q[0], exp_perr);
            check({tag, " ferr"}, vferr_q[0], exp_ferr);
            check({tag, " edge"}, vedge_q[0], VALID_EDGE);
        end
        check({tag, " busy pre"}, busy_hist[2], 0);
        check({tag, " busy rise"}, busy_hist[3], 1);
        check({tag, " busy last"}, busy_hist[VALID_EDGE - 1], 1);
        check({tag, " busy fall"}, busy_hist[VALID_EDGE], 0);
        check({tag, " held data"}, bus.Rx_DATA, d);
        last_data = d;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        bus.RxD   = 1'b1;
        bus.Rx_EN = 1'b1;
        #1;
        check("reset data", bus.Rx_DATA, 0);
        check("reset valid", bus.Rx_VALID, 0);
        check("reset perr", bus.Rx_PERROR, 0);
        check("reset ferr", bus.Rx_FERROR, 0);
        check("reset busy", bus.Rx_BUSY, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        run_frame("clean_a5", 8'hA5, 1'b0, 1'b1);
        run_frame("perr_3c", 8'h3C, 1'b1, 1'b1);
        run_frame("ferr_00", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", i), rd, rp, rs);
        end

        // Glitch: line low for 4 clocks is rejected at the start-bit centre.
        for (int c = 0; c < 4; c++) line_q.push_back(1'b0);
        play(40);
        $display("glitch: strobes=%0d", vdata_q.size());
        check("glitch strobes", vdata_q.size(), 0);
        check("glitch busy rise", busy_hist[3], 1);
        check("glitch busy fall", busy_hist[11], 0);
        check("glitch held data", bus.Rx_DATA, last_data);

        // Abort: enable drops at tick 50 of the frame.
        push_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, BIT_CLKS);
        abort_edge = 3 + 50;
        play(11 * BIT_CLKS + 40);
        abort_edge = 0;
        bus.Rx_EN = 1'b1;
        $display("abort: strobes=%0d", vdata_q.size());
        check("abort strobes", vdata_q.size(), 0);
        check("abort busy before", busy_hist[52], 1);
        check("abort busy after", busy_hist[53], 0);
        check("abort held data", bus.Rx_DATA, last_data);

        // Asynchronous reset in the middle of a frame.
        push_frame(8'h5A, 1'b0, 1'b1, BIT_CLKS);
        play(80);
        check("midreset busy before", busy_hist[80], 1);
        #2;
        reset = 1'b0;
        #1;
        $display("midreset: data=%02h busy=%0b", bus.Rx_DATA, bus.Rx_BUSY);
        check("midreset data", bus.Rx_DATA, 0);
        check("midreset valid", bus.Rx_VALID, 0);
        check("midreset perr", bus.Rx_PERROR, 0);
        check("midreset ferr", bus.Rx_FERROR, 0);
        check("midreset busy", bus.Rx_BUSY, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Pulsed ticks every 3 clocks, two frames with no idle gap.
        div = 3;
        push_frame(8'h55, 1'b0, 1'b1, 3 * BIT_CLKS);
        push_frame(8'hAA, 1'b0, 1'b1, 3 * BIT_CLKS);
        play(22 * 3 * BIT_CLKS + 200);
        $display("back2back: strobes=%0d", vdata_q.size());
        check("b2b strobes", vdata_q.size(), 2);
        if (vdata_q.size() >= 2) begin
            check("b2b data0", vdata_q[0], 8'h55);
            check("b2b data1", vdata_q[1], 8'hAA);
            check("b2b perr0", vperr_q[0], 0);
            check("b2b perr1", vperr_q[1], 0);
            check("b2b ferr0", vferr_q[0], 0);
            check("b2b ferr1", vferr_q[1], 0);
        end
        check("b2b idle busy", bus.Rx_BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Frame-level UART receive sequencer. Consumes the 16x oversampling tick (`sample_ENABLE`) produced by a separately instantiated `baud_controller` and uses it to detect start bits, sample bit centres and assemble 8N-E-1 frames (8 data bits LSB-first, even parity, 1 stop bit). It presents the received byte, a one-cycle valid strobe and parity/framing error flags to the receiver top level.

## Interface
**Parameters**
- `DATA_BITS`, 8: data bits per frame.
- `OVERSAMPLE`, 16: `sample_ENABLE` ticks per bit; a power of two is required.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sample_ENABLE` in 1: oversampling tick, normally one `clk` wide. Every high cycle counts as one tick.
- `Rx_EN` in 1: receiver enable. Low aborts or ignores any frame.
- `RxD` in 1: serial line, idle high, asynchronous to `clk`.
- `Rx_DATA` out `DATA_BITS`: last completed byte.
- `Rx_VALID` out 1: one-`clk` strobe on frame completion.
- `Rx_PERROR` out 1: parity error of the last completed frame.
- `Rx_FERROR` out 1: framing error (stop bit sampled 0) of the last completed frame.
- `Rx_BUSY` out 1: high while in any state other than IDLE.

## Operation
- **Synchronizer.** `RxD` passes through a 2-flop synchronizer that resets to 1, giving `rxd_s`. All bit timing below refers to `rxd_s`.
- **States:**
  - `IDLE`: waiting for a start bit.
  - `START`
  - `DATA`
  - `PARITY`
  - `STOP`
- **Counters:**
  - `tick_cnt`: 4 bits, modulo `OVERSAMPLE`.
  - `bit_cnt`: 3 bits.
  - `shift`: `DATA_BITS`-wide shift register.
- **Start detection (IDLE).** On a tick with `Rx_EN`=1 and `rxd_s`=0, go to `START`. This detection tick is tick 0; `tick_cnt` is set to 1.
- **Bit timing.** Bit k of the frame is the start bit for k=0, data for k=1..8, parity for k=9 and stop for k=10.
  - Bit k is sampled on tick 16k+8, i.e. `tick_cnt`==8 within the bit.
  - The state advances when `tick_cnt` wraps from 15 to 0.
- **START.** At the centre sample:
  - `rxd_s`=1 is a false start: go to `IDLE` the next cycle, with no strobe.
  - `rxd_s`=0 continues the frame.
- **DATA.** Each centre sample is shifted in LSB-first. After `DATA_BITS` bits, go to `PARITY`.
- **PARITY.** Capture `par_err` = (sampled bit) XOR (XOR-reduction of `shift`).
- **STOP.** At the centre sample (tick 168):
  - Load `Rx_DATA`←`shift`, `Rx_PERROR`←`par_err`, `Rx_FERROR`←~`rxd_s`.
  - Pulse `Rx_VALID` for one cycle.
  - Go to `IDLE` without waiting out the second half of the stop bit, so back-to-back frames are accepted.
- **Output retention.** `Rx_DATA`, `Rx_PERROR` and `Rx_FERROR` hold until the next completed frame. They are updated even when the frame has errors.
- **Rx_EN low in a non-IDLE state:** go to `IDLE` on the next clock. No strobe; the held outputs are unchanged. Abort wins over a simultaneous tick.
- **Reset (async, any time):**
  - State = `IDLE`; counters = 0.
  - `Rx_DATA`=0, `Rx_VALID`=0, `Rx_PERROR`=0, `Rx_FERROR`=0, `Rx_BUSY`=0.
  - Synchronizer flops = 1.
- **Tick handling.** Cycles without `sample_ENABLE` change nothing except the synchronizer and the abort path.

## Timing
- `RxD` to `rxd_s`: 2 `clk`.
- `Rx_VALID` is registered: it is high the cycle after the STOP centre-sample tick, for exactly 1 cycle.
- `Rx_DATA`, `Rx_PERROR` and `Rx_FERROR` become valid in the same cycle as `Rx_VALID` rises.
- Detection tick to `Rx_VALID`: 168 ticks + 1 `clk`.
- `Rx_BUSY`:
  - rises the cycle after the detection tick;
  - falls the cycle after the STOP sample, a false start, or an abort.
- Earliest next start detection: the first tick after returning to `IDLE`.

## Structure
- Shared include `uart_defs.vh`:
  - state encodings `ST_IDLE` … `ST_STOP`;
  - `OVERSAMPLE`, `SAMPLE_POINT`=8, `DATA_BITS`.
- Sub-module `rx_sync`: the 2-flop synchronizer with reset value 1.
- Top-level connection: the FSM, counters and shift register live in `uart_rx_controller`. `baud_controller` is instantiated beside it in the receiver top, with its `sample_ENABLE` wired to this block's `sample_ENABLE`.

## Test plan
All scenarios except the last tie `sample_ENABLE`=1, so 1 bit = 16 clk.

- **Clean frame, 0xA5.** Drive `RxD` = 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Required: `Rx_DATA`=0xA5, `Rx_VALID` high exactly 1 cycle at clk 2+168+1 after the start edge, `Rx_PERROR`=0, `Rx_FERROR`=0.
- **Parity error, 0x3C.** Send 0x3C with parity bit 1. Required: `Rx_DATA`=0x3C, `Rx_PERROR`=1, `Rx_FERROR`=0, one strobe.
- **Framing error.** Send 0x00 with correct parity 0 and stop bit 0. Required: `Rx_FERROR`=1, `Rx_PERROR`=0, `Rx_DATA`=0x00.
- **Glitch.** Hold `RxD` low for 4 ticks, then high. Required: no `Rx_VALID`; `Rx_BUSY` falls by tick 9 after detection.
- **Abort and reset.**
  - Drop `Rx_EN` at tick 50 of a frame. Required: `Rx_BUSY`=0 the next cycle, no strobe, previous `Rx_DATA` retained.
  - Assert `reset`=0 mid-frame. Required: all outputs 0 immediately.
- **Real baud timing, back-to-back.** Use a real `baud_controller` tick with 1-cycle pulses, and send 0x55 then 0xAA back-to-back with no idle gap. Required: two strobes, `Rx_DATA`=0x55 then 0xAA, no errors.
